// File: rtl/crc_stream_engine.sv
// Streaming reflected-CRC engine: generate mode appends the CRC after the payload,
// check mode passes the frame through and compares the register against RESIDUE.
module crc_stream_engine #(
  parameter int               CRC_W   = 16,
  parameter logic [CRC_W-1:0] POLY    = 16'hA001,
  parameter logic [CRC_W-1:0] INIT    = 16'hFFFF,
  parameter logic [CRC_W-1:0] XOROUT  = 16'h0000,
  parameter logic [CRC_W-1:0] RESIDUE = 16'h0000,
  parameter int               LEN_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             mode_i,
  input  logic [7:0]       s_data_i,
  input  logic             s_valid_i,
  input  logic             s_last_i,
  output logic             s_ready_o,
  output logic [7:0]       m_data_o,
  output logic             m_valid_o,
  output logic             m_last_o,
  input  logic             m_ready_i,
  output logic [CRC_W-1:0] crc_o,
  output logic [LEN_W-1:0] len_o,
  output logic             done_o,
  output logic             crc_ok_o,
  output logic             busy_o
);

  // Handshake: a byte moves on either side only in a cycle where valid and ready
  // are both high; m_valid_o/m_data_o/m_last_o are held stable until taken.

  typedef enum logic {S_DATA = 1'b0, S_APPEND = 1'b1} state_e;

  localparam logic [1:0] LAST_IDX = 2'(CRC_W / 8 - 1);

  state_e           state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CRC_W-1:0] shift_q, shift_d;
  logic [1:0]       idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic             done_q, done_d;
  logic             crc_ok_q, crc_ok_d;
  logic             busy_q, busy_d;
  logic             mode_q, mode_d;
  logic             first_q, first_d;

  logic             reg_free;
  logic             accept;
  logic             mode_eff;
  logic [CRC_W-1:0] crc_upd;

  function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c,
                                                input logic [7:0] b);
    logic [CRC_W-1:0] x;
    x = c ^ CRC_W'(b);
    for (int i = 0; i < 8; i++) begin
      x = x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
    end
    return x;
  endfunction

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    len_d     = len_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    done_d    = 1'b0;
    crc_ok_d  = crc_ok_q;
    busy_d    = busy_q;
    mode_d    = mode_q;
    first_d   = first_q;

    reg_free  = !m_valid_q || m_ready_i;
    s_ready_o = (state_q == S_DATA) && reg_free;
    accept    = s_valid_i && s_ready_o;
    mode_eff  = first_q ? mode_i : mode_q;
    crc_upd   = crc_byte(crc_q, s_data_i);

    if (reg_free) m_valid_d = 1'b0;

    unique case (state_q)
      S_DATA: begin
        if (accept) begin
          crc_d     = crc_upd;
          m_valid_d = 1'b1;
          m_data_d  = s_data_i;
          m_last_d  = s_last_i && mode_eff;
          len_d     = first_q ? LEN_W'(1) : ((&len_q) ? len_q : len_q + LEN_W'(1));
          mode_d    = mode_eff;
          first_d   = 1'b0;
          busy_d    = 1'b1;
          if (s_last_i) begin
            if (!mode_eff) begin
              shift_d = crc_upd ^ XOROUT;
              idx_d   = 2'd0;
              state_d = S_APPEND;
            end else begin
              crc_ok_d = (crc_upd == RESIDUE);
              done_d   = 1'b1;
              crc_d    = INIT;
              first_d  = 1'b1;
              busy_d   = 1'b0;
            end
          end
        end
      end
      S_APPEND: begin
        if (reg_free) begin
          m_valid_d = 1'b1;
          m_data_d  = shift_q[7:0];
          m_last_d  = 1'b0;
          shift_d   = shift_q >> 8;
          idx_d     = idx_q + 2'd1;
          if (idx_q == LAST_IDX) begin
            m_last_d = 1'b1;
            done_d   = 1'b1;
            crc_ok_d = 1'b1;
            crc_d    = INIT;
            first_d  = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_DATA;
          end
        end
      end
      default: state_d = S_DATA;
    endcase

    // Abort wins over anything accepted this cycle; the last result is kept.
    if (clr) begin
      state_d   = S_DATA;
      crc_d     = INIT;
      len_d     = '0;
      idx_d     = 2'd0;
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
      done_d    = 1'b0;
      crc_ok_d  = crc_ok_q;
      busy_d    = 1'b0;
      first_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_DATA;
      crc_q     <= INIT;
      shift_q   <= '0;
      idx_q     <= 2'd0;
      len_q     <= '0;
      m_data_q  <= 8'h00;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      done_q    <= 1'b0;
      crc_ok_q  <= 1'b0;
      busy_q    <= 1'b0;
      mode_q    <= 1'b0;
      first_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      done_q    <= done_d;
      crc_ok_q  <= crc_ok_d;
      busy_q    <= busy_d;
      mode_q    <= mode_d;
      first_q   <= first_d;
    end
  end

  assign m_data_o  = m_data_q;
  assign m_valid_o = m_valid_q;
  assign m_last_o  = m_last_q;
  assign crc_o     = crc_q;
  assign len_o     = len_q;
  assign done_o    = done_q;
  assign crc_ok_o  = crc_ok_q;
  assign busy_o    = busy_q;

endmodule

// File: doc/crc_stream_engine.md
Name: crc_stream_engine

Overview:
- Parametrised, streaming CRC engine for the fieldbus byte path; generalises the fixed Modbus CRC16 block.
- Byte stream in and byte stream out, with valid/ready handshakes and frame delimiting.
- Two modes, selectable per frame:
  - Generate: passes the payload through and appends the CRC bytes.
  - Check: passes the frame, including its trailing CRC, through and reports pass/fail.
- Sits between the UART byte layer and the protocol framer/deframer.

Parameters:
- CRC_W, 16, CRC width in bits. Must be a multiple of 8, range 8..32.
- POLY, 16'hA001, polynomial in reflected (LSB-first) form. Width CRC_W.
- INIT, 16'hFFFF, register value at frame start, after rst and after clr. Width CRC_W.
- XOROUT, 16'h0000, XORed onto the final CRC before it is appended. Width CRC_W.
- RESIDUE, 16'h0000, register value after a correct frame plus CRC has been processed. Compared in check mode. Width CRC_W.
- LEN_W, 16, width of the frame byte counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- clr  in  1  synchronous frame abort/clear.
- mode_i  in  1  0 = generate/append, 1 = check. Sampled on the first accepted byte of each frame.
- s_data_i  in  8  input byte.
- s_valid_i  in  1  input byte valid.
- s_last_i  in  1  input byte is the last byte of the frame.
- s_ready_o  out  1  engine accepts the input byte.
- m_data_o  out  8  output byte.
- m_valid_o  out  1  output byte valid.
- m_last_o  out  1  output byte is the last byte of the frame.
- m_ready_i  in  1  downstream accepts the output byte.
- crc_o  out  CRC_W  running CRC register (raw, XOROUT not applied).
- len_o  out  LEN_W  bytes accepted in the current or last frame. Saturating.
- done_o  out  1  one-cycle pulse at frame completion.
- crc_ok_o  out  1  result of the last completed frame. Held until the next done_o.
- busy_o  out  1  high while a frame is in progress or CRC bytes are pending.

Behaviour:
- Reset values (rst): crc = INIT, state = S_DATA.
  - All outputs 0: m_valid_o, m_data_o, m_last_o, len_o, done_o, crc_ok_o, busy_o.
- Per-byte update:
  - x = crc ^ {0, byte}.
  - Then 8 iterations of: x = x[0] ? (x>>1)^POLY : x>>1.
  - Exactly one update per accepted byte.
- Output register:
  - Single output register stage, so input-to-output latency is 1 cycle.
  - Holds while m_valid_o=1 and m_ready_i=0.
  - reg_free = !m_valid_o | m_ready_i.
- S_DATA:
  - s_ready_o = reg_free.
  - On accept (s_valid_i & s_ready_o):
    - crc is updated.
    - Output register loads the byte.
    - len_o increments, saturating at all-ones. On the first byte of a frame, len_o = 1 and mode_i is latched.
    - m_last_o = s_last_i & mode_latched.
  - On an accepted last byte, generate mode:
    - shift reg = updated crc ^ XOROUT.
    - idx = 0.
    - Go to S_APPEND.
  - On an accepted last byte, check mode:
    - crc_ok_o = (updated crc == RESIDUE).
    - done_o pulses.
    - crc = INIT.
    - Stay in S_DATA; the next byte starts a new frame.
- S_APPEND:
  - s_ready_o = 0.
  - Each cycle with reg_free:
    - Output loads shift[7:0].
    - shift >>= 8.
    - idx increments.
  - When idx == CRC_W/8-1:
    - m_last_o = 1.
    - done_o pulses.
    - crc_ok_o = 1.
    - crc = INIT.
    - Go to S_DATA.
  - Bytes go out LSB first.
- busy_o = 1 from the first accepted byte until done_o, and for the whole of S_APPEND.
- clr (or rst) aborts immediately:
  - crc = INIT, len_o = 0, state = S_DATA, m_valid_o = 0.
  - No done_o pulse; crc_ok_o is unchanged (rst clears it).
  - rst has priority over clr; clr has priority over a same-cycle accept.
- Frame boundaries:
  - A 1-byte frame is legal.
  - Back-to-back frames are legal with no idle cycle, except that generate mode stalls input for CRC_W/8 append cycles.
  - If s_valid_i drops mid-frame, the engine waits; there is no timeout.

Test Plan:
- Generate mode, frame 01 03 00 00 00 01, m_ready_i=1 → output 01 03 00 00 00 01 84 0A; m_last_o only on 0A; done_o one pulse; crc_ok_o=1; len_o=6.
- Check mode, frame 01 03 00 00 00 01 84 0A → pass-through with m_last_o on 0A; crc_ok_o=1. Same frame with the last byte 0B → crc_ok_o=0.
- Generate mode, ASCII "123456789" → appended bytes 37 4B (CRC 0x4B37). Toggle m_ready_i randomly → identical byte sequence, no drop or duplicate, s_ready_o=0 during append.
- clr asserted after byte 3 of a 6-byte frame, while m_valid_o=1 → m_valid_o=0 next cycle, crc_o=FFFF, len_o=0, no done_o. The next full frame produces the correct CRC.
- Back-to-back check-mode frames, a good 8-byte frame then a 1-byte frame → two done_o pulses; crc_ok_o=1 then 0; crc_o=FFFF after each.
- Instance with CRC_W=32, POLY=EDB88320, INIT=FFFFFFFF, XOROUT=FFFFFFFF, RESIDUE=DEBB20E3:
  - Generate mode, "123456789" → appended 26 39 F4 CB.
  - Check mode, "123456789" followed by those 4 bytes → crc_ok_o=1.
